// File: rtl/seq_add_pkg.sv
// Shared types and constants for the sequential wide adder.
// Imported by seq_wide_adder_ctrl.
package seq_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SLICE_W = 4;

endpackage

// File: rtl/seq_wide_adder_ctrl_nibble_adder.sv
// Combinational 4-bit ripple-carry slice shared by every pass
// of the sequential wide adder.
module nibble_adder
    import seq_add_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SLICE_W];

endmodule

// File: rtl/seq_wide_adder_ctrl.sv
// WIDTH-bit adder built from one 4-bit slice, one nibble per cycle.
// Define SEQ_ADD_SUB_EN to add the in_sub (A - B) port.
module seq_wide_adder_ctrl
    import seq_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef SEQ_ADD_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int CHUNKS = WIDTH / SLICE_W;
    localparam int IDXW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(CHUNKS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;

    logic [SLICE_W-1:0] a_nib, b_nib, s_nib;
    logic               s_cout;

    assign a_nib = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
    assign b_nib = b_q[int'(idx_q)*SLICE_W +: SLICE_W];

    nibble_adder u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (s_nib),
        .cout (s_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
`ifdef SEQ_ADD_SUB_EN
                    // Two's-complement subtract: invert B, carry-in 1.
                    if (in_sub) begin
                        b_d     = ~in_b;
                        carry_d = 1'b1;
                    end
`endif
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(idx_q)*SLICE_W +: SLICE_W] = s_nib;
                carry_d = s_cout;
                if (idx_q == LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = out_valid ? sum_q : '0;
    assign out_cout  = out_valid & carry_q;

endmodule

// File: doc/seq_wide_adder_ctrl.md
# seq_wide_adder_ctrl

Multi-cycle sequencer that performs WIDTH-bit additions by time-multiplexing a single 4-bit ripple adder slice, least-significant nibble first, carrying between cycles through a register. It sits between an operand producer and a result consumer with valid/ready handshakes on both sides. It trades latency for area in arithmetic paths where a full-width adder is not justified.

## Interface
Parameters:
- WIDTH, 16, operand/result width; multiple of 4, minimum 8
- CHUNKS, WIDTH/4, derived (localparam), number of slice passes

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand set presented
- in_ready  out  1  block can accept operands
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in to bit 0
- in_sub  in  1  subtract select (present only with SEQ_ADD_SUB_EN)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of bit WIDTH-1
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid: latch in_a, in_b, in_cin (and in_sub), set carry register = cin, chunk index = 0, go to RUN.
- RUN: the slice adds a_reg[4i+3:4i], b_reg[4i+3:4i] and the carry register, where i = chunk index. At each edge, sum nibble written into sum_reg[4i+3:4i], carry register = slice carry-out, i increments. On the edge where i == CHUNKS-1, go to DONE.
- DONE: out_valid=1, out_sum = sum_reg, out_cout = carry register. Hold all outputs stable until out_ready=1, then go to IDLE.
- in_ready=0 in RUN and DONE. Operands presented then are ignored, not queued.
- Arithmetic is modulo 2^WIDTH. out_cout is the true carry out of the full-width sum.
- Chunk index width is clog2(CHUNKS). It never wraps past CHUNKS-1.
- Reset, asserted at any time including mid-RUN: state=IDLE, in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0, index=0, carry=0. A partial result is discarded.

## Timing
- Accept at edge T (in_valid & in_ready).
- Chunk k is written at edge T+1+k.
- out_valid rises after edge T+CHUNKS, giving latency CHUNKS cycles.
- Handshake completes at the first edge with out_valid & out_ready. in_ready is 1 from the next cycle.
- Minimum issue interval is CHUNKS+1 cycles (5 for WIDTH=16).
- out_ready may be held high permanently, giving DONE a duration of one cycle.
- No combinational path from in_* to out_*. in_ready and out_valid are decoded from registered state only.

## Configuration
- SEQ_ADD_SUB_EN defined:
  - Adds in_sub, latched at accept.
  - When in_sub=1: b_reg stores ~in_b and the initial carry is forced to 1, so in_cin is ignored.
  - out_cout=1 means no borrow (A >= B unsigned).
- SEQ_ADD_SUB_EN undefined:
  - No in_sub port.
  - Add only; in_cin is always used.

## Structure
- Shared package seq_add_pkg:
  - FSM state enum (IDLE/RUN/DONE).
  - Constant SLICE_W=4.
- One sub-module, nibble_adder: a combinational 4-bit ripple slice with inputs a[3:0], b[3:0], cin and outputs sum[3:0], cout. Instantiated once; the controller drives its inputs from the nibble-select muxes.

## Test plan
WIDTH=16 for all scenarios.
- Basic add: in_a=0x00FF, in_b=0x0001, cin=0. out_valid exactly 4 cycles after accept; out_sum=0x0100, out_cout=0.
- Full-width carry: in_a=0xFFFF, in_b=0x0001, cin=0. out_sum=0x0000, out_cout=1. Carry is verified to propagate through all 4 passes.
- Carry-in: in_a=0x1234, in_b=0x4321, cin=1. out_sum=0x5556, out_cout=0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid.
  - out_sum/out_cout stay stable and in_ready stays 0.
  - A new in_valid offered during this window is not accepted.
  - Release out_ready: in_ready rises the next cycle.
- Reset mid-RUN: assert rst after chunk 1. All outputs return to reset values immediately. A following 0x0003+0x0004 yields 0x0007 with no residue from the aborted operation.
- With SEQ_ADD_SUB_EN defined, in_sub=1:
  - 0x0005-0x0007 gives out_sum=0xFFFE, out_cout=0.
  - 0x0007-0x0005 gives 0x0002, out_cout=1.
